// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Three-way arbiter for a 512Kx8 asynchronous SRAM (video, CPU,
//               loader) with SETUP/STROBE/HOLD sequencing and loader aging.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int ACC_CYCLES = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vid_req,
    input  logic [18:0] vid_addr,
    output logic        vid_ack,
    output logic [7:0]  vid_rdata,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_page,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        ldr_req,
    input  logic [18:0] ldr_addr,
    input  logic [7:0]  ldr_wdata,
    output logic        ldr_ack,
    output logic [18:0] sram_addr,
    output logic [7:0]  sram_dq_o,
    output logic        sram_dq_oe,
    input  logic [7:0]  sram_dq_i,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_SETUP   = 2'd1;
    localparam logic [1:0] c_STROBE  = 2'd2;
    localparam logic [1:0] c_HOLD    = 2'd3;

    localparam logic [1:0] c_OWN_VID = 2'd0;
    localparam logic [1:0] c_OWN_CPU = 2'd1;
    localparam logic [1:0] c_OWN_LDR = 2'd2;

    localparam int                 c_AGE_W    = $clog2(STARVE_MAX + 1);
    localparam logic [c_AGE_W-1:0] c_AGE_MAX  = c_AGE_W'(STARVE_MAX);
    localparam logic [c_AGE_W-1:0] c_AGE_ONE  = c_AGE_W'(1);
    localparam logic [3:0]         c_CNT_LOAD = 4'(ACC_CYCLES - 1);

    logic [1:0]         r_state;
    logic [1:0]         r_owner;
    logic               r_we;
    logic [3:0]         r_cnt;
    logic [c_AGE_W-1:0] r_age;

    logic               w_grant;
    logic               w_ldr_first;
    logic [1:0]         w_sel;
    logic [18:0]        w_addr;
    logic               w_we;
    logic [7:0]         w_wdata;

    // Aged loader only ever overtakes the CPU; video always wins.
    always_comb begin
        w_ldr_first = (r_age == c_AGE_MAX);
        w_grant     = vid_req | cpu_req | ldr_req;
        w_sel       = c_OWN_LDR;
        if (vid_req) begin
            w_sel = c_OWN_VID;
        end else if (ldr_req && w_ldr_first) begin
            w_sel = c_OWN_LDR;
        end else if (cpu_req) begin
            w_sel = c_OWN_CPU;
        end

        w_addr  = vid_addr;
        w_we    = 1'b0;
        w_wdata = 8'h00;
        case (w_sel)
            c_OWN_CPU: begin
                w_addr  = {cpu_page, cpu_addr};
                w_we    = cpu_we;
                w_wdata = cpu_wdata;
            end
            c_OWN_LDR: begin
                w_addr  = ldr_addr;
                w_we    = 1'b1;
                w_wdata = ldr_wdata;
            end
            default: begin
                w_addr  = vid_addr;
                w_we    = 1'b0;
                w_wdata = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_IDLE;
            r_owner    <= c_OWN_VID;
            r_we       <= 1'b0;
            r_cnt      <= 4'd0;
            r_age      <= '0;
            sram_addr  <= 19'd0;
            sram_dq_o  <= 8'h00;
            sram_dq_oe <= 1'b0;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            vid_ack    <= 1'b0;
            cpu_ack    <= 1'b0;
            ldr_ack    <= 1'b0;
            vid_rdata  <= 8'h00;
            cpu_rdata  <= 8'h00;
        end else begin
            vid_ack <= 1'b0;
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_grant) begin
                        r_state    <= c_SETUP;
                        r_owner    <= w_sel;
                        r_we       <= w_we;
                        sram_addr  <= w_addr;
                        sram_dq_o  <= w_wdata;
                        sram_dq_oe <= w_we;
                        if (w_sel == c_OWN_LDR) begin
                            r_age <= '0;
                        end else if (w_sel == c_OWN_CPU && ldr_req && r_age != c_AGE_MAX) begin
                            r_age <= r_age + c_AGE_ONE;
                        end
                    end
                end
                c_SETUP: begin
                    r_state <= c_STROBE;
                    r_cnt   <= c_CNT_LOAD;
                    if (r_we) begin
                        sram_we_n <= 1'b0;
                    end else begin
                        sram_oe_n <= 1'b0;
                    end
                end
                c_STROBE: begin
                    if (r_cnt == 4'd0) begin
                        r_state   <= c_HOLD;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        // Ack is registered here so it is high during HOLD.
                        case (r_owner)
                            c_OWN_VID: begin
                                vid_ack <= 1'b1;
                                if (!r_we) begin
                                    vid_rdata <= sram_dq_i;
                                end
                            end
                            c_OWN_CPU: begin
                                cpu_ack <= 1'b1;
                                if (!r_we) begin
                                    cpu_rdata <= sram_dq_i;
                                end
                            end
                            default: ldr_ack <= 1'b1;
                        endcase
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state    <= c_IDLE;
                    sram_dq_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
